prienc_scan: RTL and testbench
==============================

# prienc_scan

Sequential multi-hit priority encoder for CAM match vectors. It accepts a match vector over a valid/ready handshake and emits the index of every set bit, one index per cycle, in priority order (LSB first by default). An all-zero vector produces a single miss beat. It sits between the CAM match-line compare stage and the result/readout logic, where single-result priority encoding is not enough.

## Interface
- IN_WIDTH, 32, match vector width; legal range 2..1024, any value (not restricted to powers of two).
- LSB_FIRST, 1, scan order: 1 = lowest index first, 0 = highest index first.
- OUT_WIDTH, localparam, max(1, $clog2(IN_WIDTH)).
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  match vector present.
- req_ready  out  1  block can accept a vector.
- req  in  IN_WIDTH  match vector.
- flush  in  1  abort the current scan.
- idx_valid  out  1  output beat present.
- idx_ready  in  1  consumer accepts the beat.
- idx  out  OUT_WIDTH  index of the current hit bit.
- idx_last  out  1  final beat of this vector.
- idx_miss  out  1  vector was all zero; idx = 0.
- hit_cnt  out  OUT_WIDTH+1  popcount of the accepted vector (only with PRIENC_SCAN_CNT_EN).

## Operation
- State machine with three states: IDLE, SCAN, MISS.
- IDLE: req_ready = 1, idx_valid = 0. On req_valid && req_ready, load req into the pending register pend. Go to MISS if req == 0, otherwise go to SCAN.
- SCAN: idx_valid = 1. idx = priority encode of pend in LSB_FIRST order. idx_last = 1 when pend has exactly one bit set. idx_miss = 0.
  - On idx_valid && idx_ready, clear pend[idx].
  - If idx_last is also 1, go to IDLE.
- MISS: idx_valid = 1, idx = 0, idx_miss = 1, idx_last = 1. On idx_ready, go to IDLE.
- req_ready is 0 in SCAN and MISS. A req_valid presented there is held by the producer and not sampled.
- Output-side rules:
  - idx, idx_last, idx_miss and hit_cnt are stable while idx_valid && !idx_ready.
  - idx_valid never drops without a handshake, except on flush or rst.
- Only the bits of pend are scanned; unused encoder inputs up to the next power of two are tied to zero.
- flush:
  - In SCAN or MISS: clear pend and go to IDLE on the next edge.
  - If a handshake occurs in the same cycle, that beat counts as consumed, and no further beats are emitted.
  - In IDLE: no effect, and a same-cycle request is still accepted.
- rst: state goes to IDLE and pend to 0. Mid-scan, the remaining beats are discarded with no partial output.

## Timing
- Reset values: req_ready = 1, idx_valid = 0, idx = 0, idx_last = 0, idx_miss = 0, hit_cnt = 0.
- Latency: a vector accepted on edge N gives the first idx_valid in the cycle after edge N (registered state, combinational encode of pend).
- Throughput: one index per cycle while idx_ready = 1. A vector with K hits occupies K cycles.
- After the last handshake, one IDLE cycle follows before the next vector is accepted (one bubble per vector).
- Worst-case encode path: log2(IN_WIDTH)-level tree from pend to idx. It must close timing at IN_WIDTH = 1024.

## Configuration
- PRIENC_SCAN_CNT_EN defined:
  - hit_cnt port exists and is registered on acceptance as popcount(req).
  - It holds for every beat of the vector (0 for a miss) and stays constant until the next acceptance.
- PRIENC_SCAN_CNT_EN undefined: no hit_cnt port and no popcount logic.

## Test plan
- IN_WIDTH = 32, LSB_FIRST = 1, req = 32'h8000_0105, idx_ready = 1 -> beats idx 0, 2, 8, 31 on consecutive cycles; idx_last only on 31; hit_cnt = 4 (with CNT_EN).
- Same vector with LSB_FIRST = 0 -> beats 31, 8, 2, 0.
- req = 0 -> one beat with idx_miss = 1, idx = 0, idx_last = 1, hit_cnt = 0; req_ready returns 1 two cycles after acceptance.
- req = 32'h0000_0011 with idx_ready low for 3 cycles, then high -> idx = 0 held stable for 3 cycles, then beats 0, 4.
- IN_WIDTH = 20, req = 20'h80001, flush asserted together with the handshake of idx 0 -> no idx 19 beat; IDLE next cycle; a new req = 20'h00010 is then accepted and gives idx 4 with idx_last = 1.
- rst asserted during the scan of 32'hFFFF_FFFF after 5 beats -> next cycle all outputs at reset values; a following req = 1 gives idx 0 with idx_last = 1.

Source files
------------

// File: rtl/prienc_scan.sv
`default_nettype none
// ============================================================================
//  Module   : prienc_scan
//  Purpose  : Sequential multi-hit priority encoder; emits one index per set
//             bit of an accepted match vector, in priority order.
//  Option   : define PRIENC_SCAN_CNT_EN to add the hit_cnt popcount port.
//  Revision : 1.0 - initial release
// ============================================================================
module prienc_scan #(
   parameter int IN_WIDTH   = 32,
   parameter int LSB_FIRST  = 1,
   localparam int OUT_WIDTH = ($clog2(IN_WIDTH) < 1) ? 1 : $clog2(IN_WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [IN_WIDTH-1:0]  req,
   input  logic                 flush,
   output logic                 idx_valid,
   input  logic                 idx_ready,
   output logic [OUT_WIDTH-1:0] idx,
   output logic                 idx_last,
   output logic                 idx_miss
`ifdef PRIENC_SCAN_CNT_EN
   ,
   output logic [OUT_WIDTH:0]   hit_cnt
`endif
);

   localparam int c_PAD_WIDTH = 1 << OUT_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_MISS = 2'd2
   } state_t;

   state_t                r_state;
   logic [IN_WIDTH-1:0]   r_pend;
   logic [c_PAD_WIDTH-1:0] w_pad;
   logic [c_PAD_WIDTH-1:0] w_scan;
   logic [IN_WIDTH-1:0]   w_rest;
   logic [OUT_WIDTH-1:0]  w_enc;
   logic [OUT_WIDTH-1:0]  w_idx;
   logic                  w_any;
   logic                  w_last;

   always_comb begin
      w_pad                 = '0;
      w_pad[IN_WIDTH-1:0]   = r_pend;
   end

   // MSB-first scanning reuses the LSB-first tree on a bit-reversed vector;
   // reversing over the padded width makes the true index simply ~enc.
   generate
      if (LSB_FIRST != 0) begin : g_lsb
         assign w_scan = w_pad;
      end else begin : g_msb
         for (genvar j = 0; j < c_PAD_WIDTH; j++) begin : g_rev
            assign w_scan[j] = w_pad[c_PAD_WIDTH-1-j];
         end
      end
   endgenerate

   generate
      for (genvar l = 0; l <= OUT_WIDTH; l++) begin : g_lvl
         localparam int c_NODES = c_PAD_WIDTH >> l;
         logic [c_NODES-1:0]   w_v;
         logic [OUT_WIDTH-1:0] w_i [c_NODES];
         for (genvar n = 0; n < c_NODES; n++) begin : g_node
            if (l == 0) begin : g_leaf
               assign w_v[n] = w_scan[n];
               assign w_i[n] = OUT_WIDTH'(n);
            end else begin : g_join
               assign w_v[n] = g_lvl[l-1].w_v[2*n] | g_lvl[l-1].w_v[2*n+1];
               assign w_i[n] = g_lvl[l-1].w_v[2*n] ? g_lvl[l-1].w_i[2*n]
                                                   : g_lvl[l-1].w_i[2*n+1];
            end
         end
      end
   endgenerate

   assign w_any = g_lvl[OUT_WIDTH].w_v[0];
   assign w_enc = g_lvl[OUT_WIDTH].w_i[0];
   assign w_idx = (LSB_FIRST != 0) ? w_enc : ~w_enc;

   always_comb begin
      w_rest        = r_pend;
      w_rest[w_idx] = 1'b0;
   end

   assign w_last    = (w_rest == '0);

   assign req_ready = (r_state == S_IDLE);
   assign idx_valid = (r_state != S_IDLE);
   assign idx       = ((r_state == S_SCAN) && w_any) ? w_idx : '0;
   assign idx_last  = (r_state == S_MISS) || ((r_state == S_SCAN) && w_last);
   assign idx_miss  = (r_state == S_MISS);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pend  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_pend  <= req;
                  r_state <= (req == '0) ? S_MISS : S_SCAN;
               end
            end
            S_SCAN: begin
               if (flush) begin
                  r_pend  <= '0;
                  r_state <= S_IDLE;
               end else if (idx_ready) begin
                  r_pend <= w_rest;
                  if (w_last) begin
                     r_state <= S_IDLE;
                  end
               end
            end
            S_MISS: begin
               if (flush || idx_ready) begin
                  r_pend  <= '0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_pend  <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef PRIENC_SCAN_CNT_EN
   logic [OUT_WIDTH:0] w_pop;
   logic [OUT_WIDTH:0] r_cnt;

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < IN_WIDTH; i++) begin
         w_pop = w_pop + (OUT_WIDTH+1)'(req[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if ((r_state == S_IDLE) && req_valid) begin
         r_cnt <= w_pop;
      end
   end

   assign hit_cnt = r_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prienc_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prienc_scan
//  Purpose  : Directed self-checking bench for prienc_scan (LSB/MSB order,
//             miss, back-pressure, flush, mid-scan reset).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prienc_scan;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // a: 32-bit LSB-first, b: 32-bit MSB-first, c: 20-bit LSB-first
   logic        a_vld = 0, a_rrdy, a_flush = 0, a_ivld, a_irdy = 1, a_last, a_miss;
   logic [31:0] a_req = '0;
   logic [4:0]  a_idx;
   logic        b_vld = 0, b_rrdy, b_flush = 0, b_ivld, b_irdy = 1, b_last, b_miss;
   logic [31:0] b_req = '0;
   logic [4:0]  b_idx;
   logic        c_vld = 0, c_rrdy, c_flush = 0, c_ivld, c_irdy = 1, c_last, c_miss;
   logic [19:0] c_req = '0;
   logic [4:0]  c_idx;
`ifdef PRIENC_SCAN_CNT_EN
   logic [5:0]  a_cnt, b_cnt, c_cnt;
`endif

   prienc_scan #(.IN_WIDTH(32), .LSB_FIRST(1)) u_a (
      .clk(clk), .rst(rst), .req_valid(a_vld), .req_ready(a_rrdy), .req(a_req),
      .flush(a_flush), .idx_valid(a_ivld), .idx_ready(a_irdy), .idx(a_idx),
      .idx_last(a_last), .idx_miss(a_miss)
`ifdef PRIENC_SCAN_CNT_EN
      , .hit_cnt(a_cnt)
`endif
   );

   prienc_scan #(.IN_WIDTH(32), .LSB_FIRST(0)) u_b (
      .clk(clk), .rst(rst), .req_valid(b_vld), .req_ready(b_rrdy), .req(b_req),
      .flush(b_flush), .idx_valid(b_ivld), .idx_ready(b_irdy), .idx(b_idx),
      .idx_last(b_last), .idx_miss(b_miss)
`ifdef PRIENC_SCAN_CNT_EN
      , .hit_cnt(b_cnt)
`endif
   );

   prienc_scan #(.IN_WIDTH(20), .LSB_FIRST(1)) u_c (
      .clk(clk), .rst(rst), .req_valid(c_vld), .req_ready(c_rrdy), .req(c_req),
      .flush(c_flush), .idx_valid(c_ivld), .idx_ready(c_irdy), .idx(c_idx),
      .idx_last(c_last), .idx_miss(c_miss)
`ifdef PRIENC_SCAN_CNT_EN
      , .hit_cnt(c_cnt)
`endif
   );

   task automatic test_reset();
      logic [8:0] got, exp;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      exp = {1'b1, 1'b0, 5'd0, 1'b0, 1'b0};
      got = {a_rrdy, a_ivld, a_idx, a_last, a_miss};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_a: got %b expected %b", got, exp); end
      got = {b_rrdy, b_ivld, b_idx, b_last, b_miss};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_b: got %b expected %b", got, exp); end
      got = {c_rrdy, c_ivld, c_idx, c_last, c_miss};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_c: got %b expected %b", got, exp); end
`ifdef PRIENC_SCAN_CNT_EN
      n_checks++;
      if (a_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", a_cnt); end
`endif
      rst = 1'b0;
   endtask

   task automatic test_lsb_order();
      logic [4:0] exp_idx [4] = '{5'd0, 5'd2, 5'd8, 5'd31};
      logic [8:0] got, exp;
      @(negedge clk);
      a_req = 32'h8000_0105; a_vld = 1'b1; a_irdy = 1'b1;
      @(negedge clk);
      a_vld = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp = {1'b0, 1'b1, exp_idx[k], (k == 3), 1'b0};
         got = {a_rrdy, a_ivld, a_idx, a_last, a_miss};
         n_checks++;
         if (got !== exp) begin n_fail++; $display("FAIL lsb_beat%0d: got %b expected %b", k, got, exp); end
`ifdef PRIENC_SCAN_CNT_EN
         n_checks++;
         if (a_cnt !== 6'd4) begin n_fail++; $display("FAIL lsb_cnt%0d: got %0d expected 4", k, a_cnt); end
`endif
         @(negedge clk);
      end
      n_checks++;
      if ({a_rrdy, a_ivld} !== 2'b10) begin
         n_fail++; $display("FAIL lsb_idle: got %b expected 10", {a_rrdy, a_ivld});
      end
   endtask

   task automatic test_msb_order();
      logic [4:0] exp_idx [4] = '{5'd31, 5'd8, 5'd2, 5'd0};
      logic [8:0] got, exp;
      @(negedge clk);
      b_req = 32'h8000_0105; b_vld = 1'b1; b_irdy = 1'b1;
      @(negedge clk);
      b_vld = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp = {1'b0, 1'b1, exp_idx[k], (k == 3), 1'b0};
         got = {b_rrdy, b_ivld, b_idx, b_last, b_miss};
         n_checks++;
         if (got !== exp) begin n_fail++; $display("FAIL msb_beat%0d: got %b expected %b", k, got, exp); end
         @(negedge clk);
      end
      n_checks++;
      if ({b_rrdy, b_ivld} !== 2'b10) begin
         n_fail++; $display("FAIL msb_idle: got %b expected 10", {b_rrdy, b_ivld});
      end
   endtask

   task automatic test_miss();
      logic [8:0] got, exp;
      @(negedge clk);
      a_req = 32'h0; a_vld = 1'b1; a_irdy = 1'b1;
      @(negedge clk);
      a_vld = 1'b0;
      exp = {1'b0, 1'b1, 5'd0, 1'b1, 1'b1};
      got = {a_rrdy, a_ivld, a_idx, a_last, a_miss};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL miss_beat: got %b expected %b", got, exp); end
`ifdef PRIENC_SCAN_CNT_EN
      n_checks++;
      if (a_cnt !== 6'd0) begin n_fail++; $display("FAIL miss_cnt: got %0d expected 0", a_cnt); end
`endif
      @(negedge clk);
      n_checks++;
      if ({a_rrdy, a_ivld} !== 2'b10) begin
         n_fail++; $display("FAIL miss_ready_back: got %b expected 10", {a_rrdy, a_ivld});
      end
   endtask

   task automatic test_backpressure();
      logic [8:0] got, exp;
      @(negedge clk);
      a_req = 32'h0000_0011; a_vld = 1'b1; a_irdy = 1'b0;
      @(negedge clk);
      a_vld = 1'b0;
      for (int k = 0; k < 3; k++) begin
         exp = {1'b0, 1'b1, 5'd0, 1'b0, 1'b0};
         got = {a_rrdy, a_ivld, a_idx, a_last, a_miss};
         n_checks++;
         if (got !== exp) begin n_fail++; $display("FAIL bp_hold%0d: got %b expected %b", k, got, exp); end
         if (k < 2) @(negedge clk);
      end
      a_irdy = 1'b1;
      @(negedge clk);
      exp = {1'b0, 1'b1, 5'd4, 1'b1, 1'b0};
      got = {a_rrdy, a_ivld, a_idx, a_last, a_miss};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL bp_second: got %b expected %b", got, exp); end
`ifdef PRIENC_SCAN_CNT_EN
      n_checks++;
      if (a_cnt !== 6'd2) begin n_fail++; $display("FAIL bp_cnt: got %0d expected 2", a_cnt); end
`endif
      @(negedge clk);
      n_checks++;
      if (a_ivld !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got %b expected 0", a_ivld); end
   endtask

   task automatic test_flush();
      logic [8:0] got, exp;
      @(negedge clk);
      c_req = 20'h80001; c_vld = 1'b1; c_irdy = 1'b1;
      @(negedge clk);
      c_vld = 1'b0;
      exp = {1'b0, 1'b1, 5'd0, 1'b0, 1'b0};
      got = {c_rrdy, c_ivld, c_idx, c_last, c_miss};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL flush_first: got %b expected %b", got, exp); end
      c_flush = 1'b1;
      @(negedge clk);
      c_flush = 1'b0;
      n_checks++;
      if ({c_rrdy, c_ivld} !== 2'b10) begin
         n_fail++; $display("FAIL flush_idle: got %b expected 10", {c_rrdy, c_ivld});
      end
      // flush while idle must not block a same-cycle request
      c_req = 20'h00010; c_vld = 1'b1; c_flush = 1'b1;
      @(negedge clk);
      c_vld = 1'b0; c_flush = 1'b0;
      exp = {1'b0, 1'b1, 5'd4, 1'b1, 1'b0};
      got = {c_rrdy, c_ivld, c_idx, c_last, c_miss};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL flush_next: got %b expected %b", got, exp); end
`ifdef PRIENC_SCAN_CNT_EN
      n_checks++;
      if (c_cnt !== 6'd1) begin n_fail++; $display("FAIL flush_cnt: got %0d expected 1", c_cnt); end
`endif
      @(negedge clk);
      n_checks++;
      if (c_ivld !== 1'b0) begin n_fail++; $display("FAIL flush_done: got %b expected 0", c_ivld); end
   endtask

   task automatic test_rst_mid();
      logic [8:0] got, exp;
      @(negedge clk);
      a_req = 32'hFFFF_FFFF; a_vld = 1'b1; a_irdy = 1'b1;
      @(negedge clk);
      a_vld = 1'b0;
      for (int k = 0; k < 5; k++) begin
         exp = {1'b0, 1'b1, 5'(k), 1'b0, 1'b0};
         got = {a_rrdy, a_ivld, a_idx, a_last, a_miss};
         n_checks++;
         if (got !== exp) begin n_fail++; $display("FAIL rst_beat%0d: got %b expected %b", k, got, exp); end
         if (k < 4) @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp = {1'b1, 1'b0, 5'd0, 1'b0, 1'b0};
      got = {a_rrdy, a_ivld, a_idx, a_last, a_miss};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL rst_mid: got %b expected %b", got, exp); end
`ifdef PRIENC_SCAN_CNT_EN
      n_checks++;
      if (a_cnt !== 6'd0) begin n_fail++; $display("FAIL rst_mid_cnt: got %0d expected 0", a_cnt); end
`endif
      a_req = 32'h1; a_vld = 1'b1;
      @(negedge clk);
      a_vld = 1'b0;
      exp = {1'b0, 1'b1, 5'd0, 1'b1, 1'b0};
      got = {a_rrdy, a_ivld, a_idx, a_last, a_miss};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL rst_after: got %b expected %b", got, exp); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_lsb_order();
      test_msb_order();
      test_miss();
      test_backpressure();
      test_flush();
      test_rst_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
